// File: rtl/game_obj_pkg.sv
// Shared definitions for 72-bit game object records: field offsets, the
// terminator marker, movement direction codes and the responder FSM states.
package game_obj_pkg;

    localparam int OBJ_REC_W     = 72;
    localparam int WAIT_TIME_LSB = 0;
    localparam int SIZE_H_LSB    = 8;
    localparam int SIZE_W_LSB    = 16;
    localparam int POS_Y_LSB     = 24;
    localparam int POS_X_LSB     = 32;
    localparam int SPEED_LSB     = 40;
    localparam int MOVE_DIR_LSB  = 48;
    localparam int OBJ_TYPE_LSB  = 52;
    localparam int LIFETIME_LSB  = 56;

    localparam logic [7:0] OBJ_TERMINATOR = 8'hFF;

    typedef enum logic [3:0] {
        DIR_NONE  = 4'h0,
        DIR_RIGHT = 4'h1,
        DIR_LEFT  = 4'h2,
        DIR_UP    = 4'h3,
        DIR_DOWN  = 4'h4
    } move_dir_e;

    typedef struct packed {
        logic [15:0] lifetime;
        logic [3:0]  obj_type;
        move_dir_e   move_dir;
        logic [7:0]  speed;
        logic [7:0]  pos_x;
        logic [7:0]  pos_y;
        logic [7:0]  size_w;
        logic [7:0]  size_h;
        logic [7:0]  wait_time;
    } obj_record_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WAIT,
        ST_LATCH,
        ST_PF_WAIT
    } resp_state_e;

endpackage

// File: rtl/object_rom_responder_if.sv
// Sync/update handshake between game_runtime (master) and an object ROM
// responder (slave), carrying the request and the decoded record fields.
interface object_rom_responder_if #(
    parameter int STAGE_W = 8,
    parameter int INDEX_W = 20
);
    logic               sync;
    logic [STAGE_W-1:0] stage;
    logic [INDEX_W-1:0] index;
    logic               update;
    logic               busy;
    logic               end_of_stage;
    logic [7:0]         wait_time;
    logic [7:0]         size_h;
    logic [7:0]         size_w;
    logic [7:0]         pos_y;
    logic [7:0]         pos_x;
    logic [7:0]         speed;
    logic [3:0]         move_dir;
    logic [3:0]         obj_type;
    logic [15:0]        lifetime;

    modport master (
        output sync, stage, index,
        input  update, busy, end_of_stage, wait_time, size_h, size_w,
               pos_y, pos_x, speed, move_dir, obj_type, lifetime
    );

    modport slave (
        input  sync, stage, index,
        output update, busy, end_of_stage, wait_time, size_h, size_w,
               pos_y, pos_x, speed, move_dir, obj_type, lifetime
    );
endinterface

// File: rtl/obj_record_decode.sv
// Purely combinational slicing of a 72-bit object ROM word into its fields,
// plus detection of the end-of-stage terminator marker.
module obj_record_decode
    import game_obj_pkg::*;
(
    input  logic [OBJ_REC_W-1:0] rec_word,
    output obj_record_t          rec,
    output logic                 is_terminator
);

    // Split the word at the fixed field offsets and flag the terminator.
    always_comb begin
        rec           = '0;
        rec.wait_time = rec_word[WAIT_TIME_LSB +: 8];
        rec.size_h    = rec_word[SIZE_H_LSB +: 8];
        rec.size_w    = rec_word[SIZE_W_LSB +: 8];
        rec.pos_y     = rec_word[POS_Y_LSB +: 8];
        rec.pos_x     = rec_word[POS_X_LSB +: 8];
        rec.speed     = rec_word[SPEED_LSB +: 8];
        rec.move_dir  = move_dir_e'(rec_word[MOVE_DIR_LSB +: 4]);
        rec.obj_type  = rec_word[OBJ_TYPE_LSB +: 4];
        rec.lifetime  = rec_word[LIFETIME_LSB +: 16];
        is_terminator = (rec_word[WAIT_TIME_LSB +: 8] == OBJ_TERMINATOR);
    end

endmodule

// File: rtl/object_rom_responder.sv
// Responder side of the game-manager sync/update handshake: fetches the
// object record for {stage, index} from a synchronous ROM and returns the
// decoded fields with a one-cycle update pulse.
// Optional feature macro: OBJECT_PREFETCH_EN (speculative next-record shadow).
module object_rom_responder
    import game_obj_pkg::*;
#(
    parameter int ROM_LATENCY = 2,
    parameter int STAGE_W     = 8,
    parameter int INDEX_W     = 20,
    parameter int STRIDE_LOG2 = 6
) (
    input  logic                           clk,
    input  logic                           reset,
    object_rom_responder_if.slave          bus,
    output logic [STAGE_W+STRIDE_LOG2-1:0] rom_addr,
    input  logic [OBJ_REC_W-1:0]           rom_data
);

    localparam int              CNT_W = 3;
    localparam logic [CNT_W-1:0] LAT  = CNT_W'(ROM_LATENCY);

    resp_state_e                    state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [STAGE_W+STRIDE_LOG2-1:0] rom_addr_q, rom_addr_d;
    obj_record_t                    rec_q, rec_d, dec_rec;
    logic                           eos_q, eos_d, dec_term;
    logic [OBJ_REC_W-1:0]           dec_word;
    logic                           rom_ready, req_in_range;

`ifdef OBJECT_PREFETCH_EN
    logic [STAGE_W-1:0]   req_stage_q, req_stage_d, pf_stage_q, pf_stage_d;
    logic [INDEX_W-1:0]   req_index_q, req_index_d, pf_index_q, pf_index_d;
    logic [INDEX_W-1:0]   next_index;
    logic                 pf_inflight_q, pf_inflight_d;
    logic                 shadow_valid_q, shadow_valid_d, tag_hit;
    logic [OBJ_REC_W-1:0] shadow_q, shadow_d;
    assign dec_word = shadow_valid_q ? shadow_q : rom_data;
`else
    assign dec_word = rom_data;
`endif

    // cnt counts cycles since rom_addr was registered; data lands at LAT.
    assign rom_ready    = (cnt_q == LAT);
    assign req_in_range = ((bus.index >> STRIDE_LOG2) == '0);

    obj_record_decode u_decode (
        .rec_word      (dec_word),
        .rec           (dec_rec),
        .is_terminator (dec_term)
    );

    // Next-state, ROM address and field capture for fetch and prefetch paths.
    always_comb begin
        state_d    = state_q;
        cnt_d      = rom_ready ? cnt_q : cnt_q + 1'b1;
        rom_addr_d = rom_addr_q;
        rec_d      = rec_q;
        eos_d      = eos_q;
`ifdef OBJECT_PREFETCH_EN
        req_stage_d    = req_stage_q;
        req_index_d    = req_index_q;
        pf_stage_d     = pf_stage_q;
        pf_index_d     = pf_index_q;
        pf_inflight_d  = pf_inflight_q;
        shadow_valid_d = shadow_valid_q;
        shadow_d       = shadow_q;
        next_index     = req_index_q + 1'b1;
        tag_hit        = (shadow_valid_q || pf_inflight_q) &&
                         (bus.stage == pf_stage_q) && (bus.index == pf_index_q);
        if (pf_inflight_q && rom_ready) begin
            shadow_d       = rom_data;
            shadow_valid_d = 1'b1;
            pf_inflight_d  = 1'b0;
        end
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.sync) begin
`ifdef OBJECT_PREFETCH_EN
                    req_stage_d = bus.stage;
                    req_index_d = bus.index;
`endif
                    if (!req_in_range) begin
                        rec_d   = '0;
                        eos_d   = 1'b1;
                        state_d = ST_LATCH;
`ifdef OBJECT_PREFETCH_EN
                        pf_inflight_d  = 1'b0;
                        shadow_valid_d = 1'b0;
`endif
                    end
`ifdef OBJECT_PREFETCH_EN
                    else if (tag_hit && (shadow_valid_q || rom_ready)) begin
                        rec_d          = dec_rec;
                        eos_d          = dec_term;
                        state_d        = ST_LATCH;
                        shadow_valid_d = 1'b0;
                        pf_inflight_d  = 1'b0;
                    end else if (tag_hit) begin
                        state_d = ST_PF_WAIT;
                    end
`endif
                    else begin
                        rom_addr_d = {bus.stage, bus.index[STRIDE_LOG2-1:0]};
                        cnt_d      = '0;
                        state_d    = ST_ADDR;
`ifdef OBJECT_PREFETCH_EN
                        pf_inflight_d  = 1'b0;
                        shadow_valid_d = 1'b0;
`endif
                    end
                end
            end
            ST_ADDR: state_d = ST_WAIT;
            ST_WAIT: begin
                if (rom_ready) begin
                    rec_d   = dec_rec;
                    eos_d   = dec_term;
                    state_d = ST_LATCH;
                end
            end
`ifdef OBJECT_PREFETCH_EN
            ST_PF_WAIT: begin
                if (rom_ready) begin
                    rec_d          = dec_rec;
                    eos_d          = dec_term;
                    state_d        = ST_LATCH;
                    shadow_valid_d = 1'b0;
                end
            end
`endif
            ST_LATCH: begin
                state_d = ST_IDLE;
`ifdef OBJECT_PREFETCH_EN
                shadow_valid_d = 1'b0;
                if (((req_index_q >> STRIDE_LOG2) == '0) &&
                    ((next_index >> STRIDE_LOG2) == '0)) begin
                    rom_addr_d    = {req_stage_q, next_index[STRIDE_LOG2-1:0]};
                    cnt_d         = '0;
                    pf_inflight_d = 1'b1;
                    pf_stage_d    = req_stage_q;
                    pf_index_d    = next_index;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset aborts any fetch in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rom_addr_q <= '0;
            rec_q      <= '0;
            eos_q      <= 1'b0;
`ifdef OBJECT_PREFETCH_EN
            req_stage_q    <= '0;
            req_index_q    <= '0;
            pf_stage_q     <= '0;
            pf_index_q     <= '0;
            pf_inflight_q  <= 1'b0;
            shadow_valid_q <= 1'b0;
            shadow_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rom_addr_q <= rom_addr_d;
            rec_q      <= rec_d;
            eos_q      <= eos_d;
`ifdef OBJECT_PREFETCH_EN
            req_stage_q    <= req_stage_d;
            req_index_q    <= req_index_d;
            pf_stage_q     <= pf_stage_d;
            pf_index_q     <= pf_index_d;
            pf_inflight_q  <= pf_inflight_d;
            shadow_valid_q <= shadow_valid_d;
            shadow_q       <= shadow_d;
`endif
        end
    end

    assign rom_addr         = rom_addr_q;
    assign bus.update       = (state_q == ST_LATCH);
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.end_of_stage = eos_q;
    assign bus.wait_time    = rec_q.wait_time;
    assign bus.size_h       = rec_q.size_h;
    assign bus.size_w       = rec_q.size_w;
    assign bus.pos_y        = rec_q.pos_y;
    assign bus.pos_x        = rec_q.pos_x;
    assign bus.speed        = rec_q.speed;
    assign bus.move_dir     = rec_q.move_dir;
    assign bus.obj_type     = rec_q.obj_type;
    assign bus.lifetime     = rec_q.lifetime;

endmodule

// File: tb/tb_object_rom_responder.sv
// Directed self-checking bench for object_rom_responder with a pipelined
// synchronous ROM model. Extra checks run when OBJECT_PREFETCH_EN is defined.
module tb_object_rom_responder;

    localparam int ROM_LATENCY = 2;

    logic        clk;
    logic        reset;
    logic [13:0] rom_addr;
    logic [71:0] rom_data;
    logic [71:0] rom_pipe [ROM_LATENCY];
    int          checks;
    int          errors;

    object_rom_responder_if #(.STAGE_W(8), .INDEX_W(20)) bus ();

    object_rom_responder #(
        .ROM_LATENCY (ROM_LATENCY),
        .STAGE_W     (8),
        .INDEX_W     (20),
        .STRIDE_LOG2 (6)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .rom_addr (rom_addr),
        .rom_data (rom_data)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ROM contents: two hand-built records, everything else carries its own address in lifetime.
    function automatic logic [71:0] rom_word(input logic [13:0] a);
        case (a)
            14'd67:  rom_word = 72'h1234_21_10_50_40_20_10_05;
            14'd133: rom_word = 72'hBEEF_34_22_11_33_44_55_FF;
            default: rom_word = {2'b00, a, 56'h0};
        endcase
    endfunction

    // Synchronous ROM: data appears ROM_LATENCY cycles after the address.
    always @(posedge clk) begin
        rom_pipe[0] <= rom_word(rom_addr);
        for (int i = 1; i < ROM_LATENCY; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_data = rom_pipe[ROM_LATENCY-1];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // One sync pulse, optional extra sync at cycle extra_at, then a 12-cycle observation window.
    task automatic applyStimulus(input logic [7:0] st, input logic [19:0] ix, input int extra_at,
                                 input logic [7:0] ex_st, input logic [19:0] ex_ix,
                                 output int lat, output int n_upd, output logic busy_at,
                                 output logic [13:0] addr_at);
        lat = -1;
        n_upd = 0;
        busy_at = 1'b0;
        addr_at = '0;
        @(posedge clk);
        #1;
        bus.sync = 1'b1;
        bus.stage = st;
        bus.index = ix;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) bus.sync = 1'b0;
            if (extra_at > 0 && c == extra_at) begin
                bus.sync = 1'b1;
                bus.stage = ex_st;
                bus.index = ex_ix;
            end
            if (extra_at > 0 && c == extra_at + 1) bus.sync = 1'b0;
            if (bus.update) begin
                n_upd++;
                if (lat < 0) begin
                    lat = c;
                    busy_at = bus.busy;
                    addr_at = rom_addr;
                end
            end
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          lat;
        int          n_upd;
        logic        busy_at;
        logic [13:0] addr_at;
        logic [13:0] addr_after_oor;
        checks = 0;
        errors = 0;
        bus.sync = 1'b0;
        bus.stage = '0;
        bus.index = '0;
`ifdef OBJECT_PREFETCH_EN
        addr_after_oor = 14'd68;
`else
        addr_after_oor = 14'd67;
`endif

        $display("[TB] reset state");
        reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_update", bus.update, 0);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_eos", bus.end_of_stage, 0);
        checkOutput("rst_wait", bus.wait_time, 0);
        checkOutput("rst_pos_x", bus.pos_x, 0);
        checkOutput("rst_lifetime", bus.lifetime, 0);
        checkOutput("rst_rom_addr", rom_addr, 0);

        $display("[TB] normal fetch stage 1 index 3");
        applyStimulus(8'd1, 20'd3, 0, 8'd0, 20'd0, lat, n_upd, busy_at, addr_at);
        checkOutput("fetch_latency", lat, 4);
        checkOutput("fetch_n_upd", n_upd, 1);
        checkOutput("fetch_busy", busy_at, 1);
        checkOutput("fetch_rom_addr", addr_at, 67);
        checkOutput("fetch_pos_x", bus.pos_x, 8'h50);
        checkOutput("fetch_pos_y", bus.pos_y, 8'h40);
        checkOutput("fetch_size_w", bus.size_w, 8'h20);
        checkOutput("fetch_size_h", bus.size_h, 8'h10);
        checkOutput("fetch_speed", bus.speed, 8'h10);
        checkOutput("fetch_wait", bus.wait_time, 8'h05);
        checkOutput("fetch_move_dir", bus.move_dir, 4'h1);
        checkOutput("fetch_obj_type", bus.obj_type, 4'h2);
        checkOutput("fetch_lifetime", bus.lifetime, 16'h1234);
        checkOutput("fetch_eos", bus.end_of_stage, 0);
        checkOutput("fetch_busy_after", bus.busy, 0);
        checkOutput("fetch_update_after", bus.update, 0);

        $display("[TB] out-of-range index 64");
        applyStimulus(8'd1, 20'd64, 0, 8'd0, 20'd0, lat, n_upd, busy_at, addr_at);
        checkOutput("oor_latency", lat, 1);
        checkOutput("oor_n_upd", n_upd, 1);
        checkOutput("oor_eos", bus.end_of_stage, 1);
        checkOutput("oor_pos_x", bus.pos_x, 0);
        checkOutput("oor_lifetime", bus.lifetime, 0);
        checkOutput("oor_rom_addr", rom_addr, addr_after_oor);

        $display("[TB] terminator record with extra sync at N+2");
        applyStimulus(8'd2, 20'd5, 2, 8'd1, 20'd3, lat, n_upd, busy_at, addr_at);
        checkOutput("term_latency", lat, 4);
        checkOutput("term_n_upd", n_upd, 1);
        checkOutput("term_rom_addr", addr_at, 133);
        checkOutput("term_eos", bus.end_of_stage, 1);
        checkOutput("term_wait", bus.wait_time, 8'hFF);
        checkOutput("term_lifetime", bus.lifetime, 16'hBEEF);
        checkOutput("term_move_dir", bus.move_dir, 4'h4);
        checkOutput("term_pos_x", bus.pos_x, 8'h11);

        $display("[TB] sync in the update cycle");
        applyStimulus(8'd1, 20'd3, 4, 8'd1, 20'd7, lat, n_upd, busy_at, addr_at);
        checkOutput("same_cycle_latency", lat, 4);
        checkOutput("same_cycle_n_upd", n_upd, 1);
        checkOutput("same_cycle_pos_x", bus.pos_x, 8'h50);
        checkOutput("same_cycle_eos", bus.end_of_stage, 0);

        $display("[TB] reset mid-fetch");
        @(posedge clk);
        #1;
        bus.sync = 1'b1;
        bus.stage = 8'd2;
        bus.index = 20'd5;
        @(posedge clk);
        #1;
        bus.sync = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        n_upd = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (bus.update) n_upd++;
        end
        checkOutput("abort_n_upd", n_upd, 0);
        checkOutput("abort_busy", bus.busy, 0);
        checkOutput("abort_pos_x", bus.pos_x, 0);
        checkOutput("abort_eos", bus.end_of_stage, 0);
        applyStimulus(8'd1, 20'd3, 0, 8'd0, 20'd0, lat, n_upd, busy_at, addr_at);
        checkOutput("after_abort_latency", lat, 4);
        checkOutput("after_abort_pos_x", bus.pos_x, 8'h50);

`ifdef OBJECT_PREFETCH_EN
        $display("[TB] prefetch hit and miss");
        applyStimulus(8'd1, 20'd4, 0, 8'd0, 20'd0, lat, n_upd, busy_at, addr_at);
        checkOutput("pf_hit_latency", lat, 1);
        checkOutput("pf_hit_lifetime", bus.lifetime, 16'h0044);
        applyStimulus(8'd1, 20'd9, 0, 8'd0, 20'd0, lat, n_upd, busy_at, addr_at);
        checkOutput("pf_miss_latency", lat, 4);
        checkOutput("pf_miss_lifetime", bus.lifetime, 16'h0049);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
